// File: rtl/bitwise_pkg.sv
// Shared encodings and default sizing for the slice-serial bitwise unit.
package bitwise_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SLICE = 4;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/bitwise_slice.sv
// Combinational bitwise operator on one SLICE-bit chunk of the operands.
module bitwise_slice
    import bitwise_pkg::*;
#(
    parameter int SLICE = DEF_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic [1:0]       op,
    output logic [SLICE-1:0] r
);

    // Apply the selected operator to the current slice.
    always_comb begin
        r = {SLICE{1'b0}};
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            default: r = {SLICE{1'b0}};
        endcase
    end

endmodule

// File: rtl/bitwise_serial.sv
// Slice-serial AND/OR/XOR/NOR unit: accepts an operand pair, evaluates one
// slice per clock into a right-shifting result register, then holds f/zero.
module bitwise_serial
    import bitwise_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NSLICE - 1);

    state_e            state_r;
    state_e            state_next_s;
    logic [CW-1:0]     cnt_r;
    logic [WIDTH-1:0]  x_r;
    logic [WIDTH-1:0]  y_r;
    logic [1:0]        op_r;
    logic [WIDTH-1:0]  f_r;
    logic              zero_r;
    logic [SLICE-1:0]  a_s;
    logic [SLICE-1:0]  b_s;
    logic [SLICE-1:0]  r_s;
    logic [WIDTH-1:0]  f_shift_s;
    logic              accept_s;
    logic              last_s;

    assign in_ready  = (state_r == S_IDLE);
    assign out_valid = (state_r == S_DONE);
    assign f         = f_r;
    assign zero      = zero_r;

    assign accept_s  = in_valid && (state_r == S_IDLE);
    assign last_s    = (state_r == S_RUN) && (cnt_r == CNT_LAST);
    // Slices enter at the MSB end so slice 0 lands at the bottom after NSLICE shifts.
    assign f_shift_s = {r_s, f_r[WIDTH-1:SLICE]};

    // Select the captured operand slices addressed by the slice counter.
    always_comb begin
        a_s = x_r[cnt_r*SLICE +: SLICE];
        b_s = y_r[cnt_r*SLICE +: SLICE];
    end

    bitwise_slice #(.SLICE(SLICE)) u_slice (
        .a  (a_s),
        .b  (b_s),
        .op (op_r),
        .r  (r_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (in_valid) begin
                    state_next_s = S_RUN;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_DONE;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Operand capture, slice counter, result shift register and zero flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r    <= {WIDTH{1'b0}};
            y_r    <= {WIDTH{1'b0}};
            op_r   <= 2'b00;
            cnt_r  <= {CW{1'b0}};
            f_r    <= {WIDTH{1'b0}};
            zero_r <= 1'b0;
        end else if (accept_s) begin
            x_r    <= x;
            y_r    <= y;
            op_r   <= op;
            cnt_r  <= {CW{1'b0}};
            f_r    <= {WIDTH{1'b0}};
            zero_r <= 1'b0;
        end else if (state_r == S_RUN) begin
            f_r   <= f_shift_s;
            cnt_r <= cnt_r + CW'(1);
            if (last_s) begin
                zero_r <= (f_shift_s == {WIDTH{1'b0}});
            end else begin
                zero_r <= zero_r;
            end
        end else begin
            f_r    <= f_r;
            zero_r <= zero_r;
        end
    end

endmodule

// File: tb/tb_bitwise_serial.sv
// Directed bench for bitwise_serial with a word-level reference model and
// per-cycle output comparison.
module tb_bitwise_serial;

    localparam int NSLICE = 8;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic [31:0] y;
    logic [1:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] f;
    logic        zero;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state: 0 idle, 1 computing, 2 result held.
    int          m_stage = 0;
    int          m_left  = 0;
    logic [31:0] m_f     = 32'h0;
    int          m_cyc   = 0;
    int          m_last_acc = 0;
    int          m_prev_acc = 0;

    bitwise_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] o);
        case (o)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_stage <= 0;
            m_left  <= 0;
            m_f     <= 32'h0;
        end else begin
            m_cyc <= m_cyc + 1;
            case (m_stage)
                0: if (in_valid) begin
                    m_f        <= ref_op(x, y, op);
                    m_left     <= NSLICE - 1;
                    m_stage    <= 1;
                    m_prev_acc <= m_last_acc;
                    m_last_acc <= m_cyc;
                end
                1: if (m_left == 0) m_stage <= 2;
                   else m_left <= m_left - 1;
                default: if (out_ready) m_stage <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
            chk("rst_in_ready",  {31'b0, in_ready},  32'h1);
            chk("rst_f",         f,                  32'h0);
            chk("rst_zero",      {31'b0, zero},      32'h0);
        end else begin
            chk("in_ready",  {31'b0, in_ready},  {31'b0, m_stage == 0});
            chk("out_valid", {31'b0, out_valid}, {31'b0, m_stage == 2});
            if (m_stage == 2) begin
                chk("f",    f,             m_f);
                chk("zero", {31'b0, zero}, {31'b0, m_f == 32'h0});
            end
        end
    end

    // Called at a negedge; returns at the negedge just after the accept edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
        int k;
        in_valid = 1'b1; x = a; y = b; op = o;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) chk("accept_timeout", 32'h0, 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int k);
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) chk("out_valid_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x = 32'h0; y = 32'h0; op = 2'b00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // AND with latency check
        send(32'hF0F01234, 32'h0FF0FFFF, 2'b00);
        wait_out(k);
        chk("and_latency", k, 32'd8);
        chk("and_f", f, 32'h00F01234);
        chk("and_zero", {31'b0, zero}, 32'h0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("and_release_in_ready", {31'b0, in_ready}, 32'h1);

        // XOR self-cancel
        send(32'hDEADBEEF, 32'hDEADBEEF, 2'b10);
        wait_out(k);
        chk("xor_f", f, 32'h00000000);
        chk("xor_zero", {31'b0, zero}, 32'h1);
        out_ready = 1'b1;
        @(negedge clk);

        // OR then NOR back to back, out_ready held high
        send(32'h80000001, 32'h00000100, 2'b01);
        in_valid = 1'b1; x = 32'h0; y = 32'h0; op = 2'b11;
        wait_out(k);
        chk("or_f", f, 32'h80000101);
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_issue_period", m_last_acc - m_prev_acc, 32'd10);
        wait_out(k);
        chk("nor_f", f, 32'hFFFFFFFF);
        chk("nor_zero", {31'b0, zero}, 32'h0);
        @(negedge clk);
        out_ready = 1'b0;

        // Backpressure with competing input traffic
        send(32'h0000FFFF, 32'h00FF00FF, 2'b00);
        wait_out(k);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; x = $urandom; y = $urandom; op = 2'($urandom_range(0, 3));
            @(negedge clk);
            chk("bp_f", f, 32'h000000FF);
            chk("bp_zero", {31'b0, zero}, 32'h0);
            chk("bp_in_ready", {31'b0, in_ready}, 32'h0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", {31'b0, in_ready}, 32'h1);
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);

        // Operand stability after acceptance
        send(32'hFFFFFFFF, 32'h12345678, 2'b00);
        for (int i = 0; i < 7; i++) begin
            x = $urandom; y = $urandom; op = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        wait_out(k);
        chk("stable_f", f, 32'h12345678);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of RUN
        send(32'hA5A5A5A5, 32'hFFFFFFFF, 2'b00);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("midrst_f", f, 32'h0);
        chk("midrst_zero", {31'b0, zero}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_in_ready", {31'b0, in_ready}, 32'h1);
        send(32'hFFFF0000, 32'h0F0F0F0F, 2'b00);
        wait_out(k);
        chk("postrst_f", f, 32'h0F0F0000);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
